// File: rtl/regmap_bank.sv
// Control/status register bank: R/W control regs, W1C status, 1-cycle reads.
// Optional sticky address-error flag enabled by REGMAP_ADDR_ERR_EN.
module regmap_bank #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 3
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         WRITE,
    input  logic                         READ,
    input  logic [ADDR_W-1:0]            ADDR,
    input  logic [DATA_W-1:0]            WRITE_DATA,
    input  logic [DATA_W-1:0]            EVENT,
    output logic [DATA_W-1:0]            READ_DATA,
    output logic                         READ_VALID,
    output logic [NUM_REGS*DATA_W-1:0]   CTRL_OUT,
    output logic                         IRQ,
    output logic                         ADDR_ERR
);

    localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(NUM_REGS);

    logic [DATA_W-1:0] ctrl_q [NUM_REGS];
    logic [DATA_W-1:0] ctrl_d [NUM_REGS];
    logic [DATA_W-1:0] stat_q;
    logic [DATA_W-1:0] stat_d;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rd_mux;
    logic [DATA_W-1:0] w1c_mask;
    logic              rvalid_q;
    logic              stat_sel;
    logic              out_rng;

    assign stat_sel = (ADDR == STAT_ADDR);
    assign out_rng  = (ADDR > STAT_ADDR);

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            ctrl_d[k] = ctrl_q[k];
            if (ADDR == ADDR_W'(k)) begin
                rd_mux = ctrl_q[k];
                if (WRITE) ctrl_d[k] = WRITE_DATA;
            end
        end
        if (stat_sel) rd_mux = stat_q;
    end

    // Event set is OR'd after the clear so a same-cycle event wins.
    assign w1c_mask = (WRITE && stat_sel) ? WRITE_DATA : '0;
    assign stat_d   = (stat_q & ~w1c_mask) | EVENT;
    assign rdata_d  = READ ? rd_mux : rdata_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < NUM_REGS; k++) ctrl_q[k] <= '0;
            stat_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) ctrl_q[k] <= ctrl_d[k];
            stat_q   <= stat_d;
            rdata_q  <= rdata_d;
            rvalid_q <= READ;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrl_out
        assign CTRL_OUT[g*DATA_W +: DATA_W] = ctrl_q[g];
    end

    assign READ_DATA  = rdata_q;
    assign READ_VALID = rvalid_q;
    assign IRQ        = |stat_q;

`ifdef REGMAP_ADDR_ERR_EN
    logic err_q;
    logic err_d;

    always_comb begin
        err_d = err_q;
        if (WRITE && stat_sel && WRITE_DATA[DATA_W-1]) err_d = 1'b0;
        if ((READ || WRITE) && out_rng) err_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign ADDR_ERR = err_q;
`else
    assign ADDR_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_regmap_bank.sv
// Directed self-checking bench for regmap_bank (default parameters).
module tb_regmap_bank;

    logic        CLK;
    logic        RST_N;
    logic        WRITE;
    logic        READ;
    logic [2:0]  ADDR;
    logic [7:0]  WRITE_DATA;
    logic [7:0]  EVENT;
    logic [7:0]  READ_DATA;
    logic        READ_VALID;
    logic [31:0] CTRL_OUT;
    logic        IRQ;
    logic        ADDR_ERR;

    int n_checks = 0;
    int n_errors = 0;

`ifdef REGMAP_ADDR_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    regmap_bank dut (
        .CLK(CLK), .RST_N(RST_N), .WRITE(WRITE), .READ(READ),
        .ADDR(ADDR), .WRITE_DATA(WRITE_DATA), .EVENT(EVENT),
        .READ_DATA(READ_DATA), .READ_VALID(READ_VALID),
        .CTRL_OUT(CTRL_OUT), .IRQ(IRQ), .ADDR_ERR(ADDR_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        WRITE = 0; READ = 0; EVENT = '0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        WRITE = 1; ADDR = a; WRITE_DATA = d;
        tick();
        WRITE = 0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a,
                      input logic [7:0] exp);
        READ = 1; ADDR = a;
        tick();
        READ = 0;
        check({tag, "_valid"}, 32'(READ_VALID), 32'd1);
        check({tag, "_data"}, 32'(READ_DATA), 32'(exp));
    endtask

    initial begin
        RST_N = 0; ADDR = '0; WRITE_DATA = '0;
        idle();
        tick(); tick();
        check("rst_valid", 32'(READ_VALID), 0);
        check("rst_data", 32'(READ_DATA), 0);
        check("rst_ctrl", CTRL_OUT, 0);
        check("rst_irq", 32'(IRQ), 0);
        check("rst_err", 32'(ADDR_ERR), 0);
        RST_N = 1;
        tick();

        wr(3'd2, 8'hA5);
        check("ctrl2_out", 32'(CTRL_OUT[23:16]), 32'hA5);
        rd("rd2", 3'd2, 8'hA5);
        tick();
        check("idle_valid", 32'(READ_VALID), 0);
        check("idle_hold", 32'(READ_DATA), 32'hA5);

        EVENT = 8'h03;
        tick();
        EVENT = 8'h00;
        check("ev_irq", 32'(IRQ), 1);
        rd("stat03", 3'd4, 8'h03);
        wr(3'd4, 8'h01);
        rd("stat02", 3'd4, 8'h02);
        check("irq_still", 32'(IRQ), 1);
        wr(3'd4, 8'h02);
        check("irq_clr", 32'(IRQ), 0);

        EVENT = 8'h01;
        wr(3'd4, 8'h01);
        EVENT = 8'h00;
        rd("set_wins", 3'd4, 8'h01);
        wr(3'd4, 8'h01);
        check("stat_clr", 32'(IRQ), 0);

        wr(3'd1, 8'h11);
        READ = 1; WRITE = 1; ADDR = 3'd1; WRITE_DATA = 8'h22;
        tick();
        idle();
        check("rw_old", 32'(READ_DATA), 32'h11);
        rd("rw_new", 3'd1, 8'h22);

        READ = 1; ADDR = 3'd1;
        tick();
        check("b2b1_valid", 32'(READ_VALID), 1);
        check("b2b1_data", 32'(READ_DATA), 32'h22);
        ADDR = 3'd2;
        tick();
        READ = 0;
        check("b2b2_valid", 32'(READ_VALID), 1);
        check("b2b2_data", 32'(READ_DATA), 32'hA5);

        rd("oor_rd", 3'd6, 8'h00);
        check("oor_err", 32'(ADDR_ERR), 32'(ERR_EXP));
        wr(3'd6, 8'hFF);
        wr(3'd5, 8'hFF);
        check("oor_wr_ctrl", CTRL_OUT, 32'h00A52200);
        check("oor_wr_irq", 32'(IRQ), 0);
        wr(3'd4, 8'h80);
        check("err_clr", 32'(ADDR_ERR), 0);

        wr(3'd0, 8'hFF);
        EVENT = 8'h04;
        tick();
        EVENT = 8'h00;
        READ = 1; ADDR = 3'd0;
        tick();
        READ = 0;
        check("pre_rst_data", 32'(READ_DATA), 32'hFF);
        #2 RST_N = 0;
        #1;
        check("arst_valid", 32'(READ_VALID), 0);
        check("arst_data", 32'(READ_DATA), 0);
        check("arst_ctrl", CTRL_OUT, 0);
        check("arst_irq", 32'(IRQ), 0);
        check("arst_err", 32'(ADDR_ERR), 0);
        #1 RST_N = 1;
        tick();
        check("post_valid", 32'(READ_VALID), 0);
        check("post_ctrl", CTRL_OUT, 0);
        wr(3'd3, 8'h5A);
        check("post_wr", CTRL_OUT, 32'h5A000000);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
